// File: rtl/echo_capture.sv
// Purpose : ultrasonic echo pulse-width capture; converts echo high time (us) to distance (cm).
// Latency : valid is visible after the 3rd clk_1m rising edge following the echo falling edge.
// Backpr. : none; results are single-cycle valid/timeout pulses, outputs hold until next valid.
//
// Ports:
//   clk_1m   : 1 MHz clock, one cycle per microsecond
//   rst      : asynchronous active-low reset
//   trig     : trigger level (clk_1m domain); rising edge starts a measurement
//   echo     : sensor echo pin (asynchronous, synchronised internally)
//   dist_cm  : last valid distance in cm (saturates at 1023)
//   width_us : last valid echo high width in cycles
//   valid    : one-cycle pulse when dist_cm/width_us update
//   timeout  : one-cycle pulse when a measurement is aborted
//   busy     : high while a measurement is in progress
module echo_capture #(
  parameter int WAIT_TIMEOUT = 30000,
  parameter int MAX_WIDTH    = 38000,
  parameter int US_PER_CM    = 58
) (
  input  logic        clk_1m,
  input  logic        rst,
  input  logic        trig,
  input  logic        echo,
  output logic [9:0]  dist_cm,
  output logic [15:0] width_us,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  localparam int WW = $clog2(WAIT_TIMEOUT + 1);
  localparam int SW = $clog2(US_PER_CM + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT - 1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(US_PER_CM - 1);
  localparam logic [15:0]   MAX_W     = 16'(MAX_WIDTH);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DRAIN} state_t;

  state_t        state, state_nxt;
  logic          echo_m, echo_s, echo_d, trig_d;
  logic          echo_rise, trig_rise;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [15:0]   width_cnt, width_nxt;
  logic [SW-1:0] sub_cnt, sub_nxt;
  logic [9:0]    cm_cnt, cm_nxt;
  logic [9:0]    dist_nxt;
  logic [15:0]   wid_nxt;
  logic          valid_nxt, timeout_nxt, busy_nxt;

  // Two-flop synchroniser on echo, plus one delay stage for edge detection.
  // trig is already in this clock domain, so it only gets the delay stage.
  always_ff @(posedge clk_1m or negedge rst) begin
    if (!rst) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
      trig_d <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
      trig_d <= trig;
    end
  end

  // Edge-based: an echo that is already high when ARM is entered is not a rise.
  assign echo_rise = echo_s & ~echo_d;
  assign trig_rise = trig & ~trig_d;

  always_ff @(posedge clk_1m or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      width_cnt <= '0;
      sub_cnt   <= '0;
      cm_cnt    <= '0;
      dist_cm   <= '0;
      width_us  <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      width_cnt <= width_nxt;
      sub_cnt   <= sub_nxt;
      cm_cnt    <= cm_nxt;
      dist_cm   <= dist_nxt;
      width_us  <= wid_nxt;
      valid     <= valid_nxt;
      timeout   <= timeout_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    width_nxt   = width_cnt;
    sub_nxt     = sub_cnt;
    cm_nxt      = cm_cnt;
    dist_nxt    = dist_cm;
    wid_nxt     = width_us;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (trig_rise) begin
          state_nxt = ARM;
          wait_nxt  = '0;
        end
      end

      ARM: begin
        if (echo_rise) begin
          // The rising cycle itself is the first high cycle of the pulse.
          state_nxt = MEASURE;
          width_nxt = 16'd1;
          sub_nxt   = SW'(1);
          cm_nxt    = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end else if (wait_cnt != '1) begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end

      MEASURE: begin
        if (!echo_s) begin
          state_nxt = IDLE;
          dist_nxt  = cm_cnt;
          wid_nxt   = width_cnt;
          valid_nxt = 1'b1;
        end else if (width_cnt >= MAX_W) begin
          // Echo is still high past the longest legal pulse: abort, then
          // wait for it to drop so the tail is not seen as a new pulse.
          state_nxt   = DRAIN;
          timeout_nxt = 1'b1;
        end else begin
          if (width_cnt != 16'hFFFF) width_nxt = width_cnt + 1'b1;
          // Running quotient: cm_cnt tracks floor(width / US_PER_CM).
          if (sub_cnt == SUB_LAST) begin
            sub_nxt = '0;
            if (cm_cnt != 10'h3FF) cm_nxt = cm_cnt + 1'b1;
          end else begin
            sub_nxt = sub_cnt + 1'b1;
          end
        end
      end

      DRAIN: begin
        if (!echo_s) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_echo_capture.sv
`timescale 1ns/1ps
module tb_echo_capture;

  logic        clk_1m = 1'b0;
  logic        rst    = 1'b0;
  logic        trig   = 1'b0;
  logic        echo   = 1'b0;
  logic [9:0]  dist_cm;
  logic [15:0] width_us;
  logic        valid, timeout, busy;

  int checks = 0;
  int errors = 0;

  int valid_cnt = 0;
  int to_cnt    = 0;
  int both_cnt  = 0;
  int bad_chg   = 0;
  logic [9:0]  pd = '0;
  logic [15:0] pw = '0;
  logic        rst_prev = 1'b0;

  echo_capture dut (
    .clk_1m   (clk_1m),
    .rst      (rst),
    .trig     (trig),
    .echo     (echo),
    .dist_cm  (dist_cm),
    .width_us (width_us),
    .valid    (valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk_1m = ~clk_1m;

  // Pulse and output-stability monitor, sampled on the inactive edge.
  always @(negedge clk_1m) begin
    if (valid) valid_cnt++;
    if (timeout) to_cnt++;
    if (valid && timeout) both_cnt++;
    if (rst && rst_prev && !valid && (dist_cm != pd || width_us != pw)) bad_chg++;
    pd       = dist_cm;
    pw       = width_us;
    rst_prev = rst;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // trig rise, echo rises gap cycles later and stays high hi cycles.
  task automatic run_meas(input string tag, input int gap, input int hi,
                          input int exp_w, input int exp_d);
    int v0;
    v0 = valid_cnt;
    @(negedge clk_1m); trig = 1'b1;
    repeat (gap) @(negedge clk_1m);
    trig = 1'b0;
    echo = 1'b1;
    repeat (hi) @(negedge clk_1m);
    check({tag, "_busy"}, 32'(busy), 1);
    echo = 1'b0;
    repeat (2) @(posedge clk_1m);
    #1 check({tag, "_early"}, 32'(valid), 0);
    @(posedge clk_1m);
    #1;
    check({tag, "_valid"}, 32'(valid), 1);
    check({tag, "_width"}, 32'(width_us), 32'(exp_w));
    check({tag, "_dist"},  32'(dist_cm), 32'(exp_d));
    check({tag, "_idle"},  32'(busy), 0);
    repeat (3) @(negedge clk_1m);
    check({tag, "_nvalid"}, 32'(valid_cnt - v0), 1);
  endtask

  initial begin
    int t0, v0, n;

    // Reset state
    #1;
    check("rst_dist",  32'(dist_cm), 0);
    check("rst_width", 32'(width_us), 0);
    check("rst_flags", {29'd0, valid, timeout, busy}, 0);
    repeat (3) @(negedge clk_1m);
    rst = 1'b1;
    repeat (3) @(negedge clk_1m);

    // Basic measurement and cm boundaries
    run_meas("m580", 100, 580, 580, 10);
    run_meas("m57",  20,  57,  57,  0);
    run_meas("m58",  20,  58,  58,  1);
    run_meas("m116", 20,  116, 116, 2);
    run_meas("m1",   20,  1,   1,   0);

    // No echo: wait timeout exactly 30000 cycles after the detecting edge
    t0 = to_cnt; v0 = valid_cnt;
    @(negedge clk_1m); trig = 1'b1;
    @(posedge clk_1m);
    repeat (29999) @(posedge clk_1m);
    #1 check("wto_early", 32'(timeout), 0);
    @(posedge clk_1m);
    #1;
    check("wto_pulse", 32'(timeout), 1);
    check("wto_busy",  32'(busy), 0);
    check("wto_width", 32'(width_us), 1);
    check("wto_dist",  32'(dist_cm), 0);
    trig = 1'b0;
    repeat (3) @(negedge clk_1m);
    check("wto_count", 32'(to_cnt - t0), 1);
    check("wto_novld", 32'(valid_cnt - v0), 0);

    // Over-long echo: timeout near width 38000, drain until echo low
    t0 = to_cnt; v0 = valid_cnt;
    @(negedge clk_1m); trig = 1'b1;
    repeat (5) @(negedge clk_1m);
    trig = 1'b0;
    echo = 1'b1;
    repeat (37990) @(negedge clk_1m);
    check("mw_notyet", 32'(to_cnt - t0), 0);
    repeat (110) @(negedge clk_1m);
    check("mw_to",     32'(to_cnt - t0), 1);
    check("mw_busy",   32'(busy), 1);
    repeat (1900) @(negedge clk_1m);
    check("mw_busy2",  32'(busy), 1);
    echo = 1'b0;
    repeat (5) @(negedge clk_1m);
    check("mw_idle",   32'(busy), 0);
    check("mw_novld",  32'(valid_cnt - v0), 0);
    check("mw_one_to", 32'(to_cnt - t0), 1);
    check("mw_width",  32'(width_us), 1);

    // Echo already high at trig rise must not be measured
    v0 = valid_cnt;
    @(negedge clk_1m); echo = 1'b1;
    repeat (10) @(negedge clk_1m);
    trig = 1'b1;
    repeat (10) @(negedge clk_1m);
    echo = 1'b0; trig = 1'b0;
    repeat (200) @(negedge clk_1m);
    check("pre_novld", 32'(valid_cnt - v0), 0);
    echo = 1'b1;
    repeat (290) @(negedge clk_1m);
    echo = 1'b0;
    n = 0;
    while (!valid && n < 10) begin
      @(posedge clk_1m); #1; n++;
    end
    check("pre_valid", 32'(valid), 1);
    check("pre_width", 32'(width_us), 290);
    check("pre_dist",  32'(dist_cm), 5);

    // Reset mid-measurement
    repeat (5) @(negedge clk_1m);
    v0 = valid_cnt; t0 = to_cnt;
    trig = 1'b1;
    repeat (10) @(negedge clk_1m);
    echo = 1'b1;
    repeat (302) @(negedge clk_1m);
    #2 rst = 1'b0;
    #1;
    check("mrst_dist",  32'(dist_cm), 0);
    check("mrst_width", 32'(width_us), 0);
    check("mrst_flags", {29'd0, valid, timeout, busy}, 0);
    @(negedge clk_1m);
    echo = 1'b0; trig = 1'b0;
    repeat (3) @(negedge clk_1m);
    rst = 1'b1;
    repeat (3) @(negedge clk_1m);
    echo = 1'b1;
    repeat (100) @(negedge clk_1m);
    echo = 1'b0;
    repeat (10) @(negedge clk_1m);
    check("mrst_nopulse", 32'(valid_cnt - v0 + to_cnt - t0), 0);
    check("mrst_notrig",  32'(busy), 0);
    run_meas("post", 50, 116, 116, 2);

    check("excl_pulses", 32'(both_cnt), 0);
    check("stable_outs", 32'(bad_chg), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/echo_capture.md
ECHO_CAPTURE -- requirements
Module: echo_capture

Interface
REQ-001 Parameter: WAIT_TIMEOUT, 30000, max cycles from trig rising edge to echo rising edge before timeout.
REQ-002 Parameter: MAX_WIDTH, 38000, max echo high cycles before out-of-range timeout.
REQ-003 Parameter: US_PER_CM, 58, echo cycles per centimetre of distance.
REQ-004 clk_1m  input  1  sole clock, 1 MHz, 1 cycle = 1 us, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 trig  input  1  sensor trigger level from the trigger generator, synchronous to clk_1m; its rising edge starts a measurement.
REQ-007 echo  input  1  sensor echo pin, asynchronous to clk_1m.
REQ-008 dist_cm  output  10  last valid distance, cm.
REQ-009 width_us  output  16  last valid echo high width, cycles.
REQ-010 valid  output  1  one-cycle pulse: dist_cm/width_us updated.
REQ-011 timeout  output  1  one-cycle pulse: measurement aborted.
REQ-012 busy  output  1  high while not in IDLE.

Function
REQ-013 echo SHALL pass a 2-flop synchronizer (echo_s); rise/fall SHALL be detected on echo_s versus its 1-cycle delayed copy; trig rise SHALL be detected against a 1-cycle delayed copy, no synchronizer.
REQ-014 FSM states: IDLE, ARM, MEASURE, DRAIN; all outputs registered.
REQ-015 IDLE: trig rise -> ARM, wait counter cleared; all other trig activity ignored in non-IDLE states.
REQ-016 ARM: echo_s rise -> MEASURE with width counter = 1, cm sub-counter = 1, cm counter = 0; echo_s already high on ARM entry SHALL NOT count as a rise.
REQ-017 ARM: wait counter reaching WAIT_TIMEOUT with no rise -> timeout pulse, -> IDLE.
REQ-018 MEASURE: each cycle echo_s = 1 -> width +1, sub-counter +1; sub-counter reaching US_PER_CM wraps to 0 and cm counter +1; hence dist_cm = floor(width_us / US_PER_CM), no divider.
REQ-019 MEASURE: echo_s = 0 -> latch width_us and dist_cm, valid pulse, -> IDLE; valid visible after the 3rd clk_1m rising edge following the echo falling edge.
REQ-020 MEASURE: width reaching MAX_WIDTH while echo_s = 1 -> timeout pulse, outputs unchanged, -> DRAIN.
REQ-021 DRAIN: hold until echo_s = 0, then -> IDLE; no valid, no second timeout.
REQ-022 Counters SHALL saturate, never wrap; dist_cm saturates at 1023.
REQ-023 valid and timeout SHALL never assert in the same cycle; each is exactly one cycle wide.
REQ-024 dist_cm/width_us SHALL change only in the valid cycle.
REQ-025 trig rise in the same cycle as echo_s fall in MEASURE: measurement completes, trig ignored.

Reset
REQ-026 rst low SHALL immediately force IDLE, dist_cm = 0, width_us = 0, valid = 0, timeout = 0, busy = 0, synchronizer and edge flops = 0, all counters = 0, regardless of clock.
REQ-027 Reset mid-measurement SHALL discard it with no valid or timeout pulse; after release, a trig rise is needed before any capture.

Verification
REQ-028 trig rise; echo high 580 cycles after 100 cycles -> one valid, width_us = 580, dist_cm = 10, busy falls with valid.
REQ-029 Echo widths 57 / 58 / 116 -> dist_cm 0 / 1 / 2.
REQ-030 trig rise, echo never rises -> timeout pulse 30000 cycles after trig rise detection, dist_cm/width_us keep prior values.
REQ-031 echo high 40000 cycles -> timeout at width 38000, busy held until echo low, no valid.
REQ-032 echo already high before trig rise, falls, rises 200 cycles later for 290 cycles -> dist_cm = 5.
REQ-033 rst asserted at width 300 -> outputs zero at once, no pulse; next full cycle measures correctly.
